// File: rtl/subleq_seq_controller_if.sv
// Host/datapath-facing bundle of the SUBLEQ sequencing controller.
// master = the controller, slave = the host/datapath side driving commands and mem_ready.
interface subleq_seq_controller_if #(
  parameter int unsigned STATE_BITS = 4,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  run;
  logic                  step;
  logic                  clear;
  logic                  halt;
  logic                  mem_ready;
  logic                  mem_req;
  logic [STATE_BITS-1:0] control_word;
  logic                  busy;
  logic                  halted;
  logic                  fault;
  logic [CNT_WIDTH-1:0]  retired_count;

  modport master (
    input  run, step, clear, halt, mem_ready,
    output mem_req, control_word, busy, halted, fault, retired_count
  );

  modport slave (
    output run, step, clear, halt, mem_ready,
    input  mem_req, control_word, busy, halted, fault, retired_count
  );
endinterface

// File: rtl/subleq_seq_controller.sv
// SUBLEQ sequencing FSM: six memory phases per instruction, run/step modes, retire counter.
// Define SUBLEQ_WAIT_TIMEOUT_EN to enable the memory-wait timeout fault.
module subleq_seq_controller #(
  parameter int unsigned STATE_BITS = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned MAX_WAIT   = 15
) (
  input logic                    clk,
  input logic                    areset,
  subleq_seq_controller_if.master bus
);

  if (STATE_BITS < 4) begin : gen_bad_state_bits
    $error("STATE_BITS must be at least 4");
  end
  if (MAX_WAIT < 1) begin : gen_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetchA   = 4'd1,
    StDerefA   = 4'd2,
    StFetchB   = 4'd3,
    StDerefB   = 4'd4,
    StStoreSub = 4'd5,
    StFetchC   = 4'd6,
    StHalt     = 4'd7,
    StFault    = 4'd8
  } state_e;

  state_e               state_q, state_d;
  logic                 single_q, single_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 in_phase;
  logic                 timeout;
  state_e               phase_next;

  assign in_phase = (state_q == StFetchA)  || (state_q == StDerefA) ||
                    (state_q == StFetchB)  || (state_q == StDerefB) ||
                    (state_q == StStoreSub) || (state_q == StFetchC);

`ifdef SUBLEQ_WAIT_TIMEOUT_EN
  localparam int unsigned WaitW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  logic [WaitW-1:0] wait_q, wait_d;

  assign timeout = (wait_q >= WaitW'(MAX_WAIT));

  // Any state change restarts the stall count; it never passes MAX_WAIT since that forces FAULT.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (in_phase && !bus.mem_ready) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    phase_next = StIdle;
    unique case (state_q)
      StFetchA:   phase_next = StDerefA;
      StDerefA:   phase_next = StFetchB;
      StFetchB:   phase_next = StDerefB;
      StDerefB:   phase_next = StStoreSub;
      StStoreSub: phase_next = StFetchC;
      default:    phase_next = StIdle;
    endcase
  end

  // Halt outranks everything else, including the IDLE start commands.
  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.halt) begin
          state_d = StHalt;
        end else if (bus.step) begin
          state_d  = StFetchA;
          single_d = 1'b1;
        end else if (bus.run) begin
          state_d  = StFetchA;
          single_d = 1'b0;
        end
      end
      StFetchA, StDerefA, StFetchB, StDerefB, StStoreSub: begin
        if (bus.halt) begin
          state_d = StHalt;
        end else if (bus.mem_ready) begin
          state_d = phase_next;
        end else if (timeout) begin
          state_d = StFault;
        end
      end
      StFetchC: begin
        if (bus.halt) begin
          state_d = StHalt;
        end else if (bus.mem_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (single_q || !bus.run) ? StIdle : StFetchA;
        end else if (timeout) begin
          state_d = StFault;
        end
      end
      StHalt, StFault: begin
        if (bus.clear) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= StIdle;
      single_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.control_word  = STATE_BITS'(state_q);
  assign bus.mem_req       = in_phase;
  assign bus.busy          = in_phase;
  assign bus.halted        = (state_q == StHalt);
`ifdef SUBLEQ_WAIT_TIMEOUT_EN
  assign bus.fault         = (state_q == StFault);
`else
  assign bus.fault         = 1'b0;
`endif
  assign bus.retired_count = cnt_q;

endmodule
